// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle RV32 integer core: FETCH/EXEC/WB FSM with ebreak and illegal-instruction halt
// Optional: define MULTICYCLE_RV32E_EN for a 16-entry register file that traps on register indices >= 16.
module multicycle_core #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic            halt,
   output logic            illegal,
   output logic [XLEN-1:0] halt_ret
);

`ifdef MULTICYCLE_RV32E_EN
   localparam int NREG = 16;
`else
   localparam int NREG = 32;
`endif
   localparam int RW = $clog2(NREG);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      WB    = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t state;
   state_t state_nx;

   logic [31:0]     ir;
   logic [XLEN-1:0] regs [NREG];
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] npc_q;
   logic            wr_q;
   logic [RW-1:0]   rd_q;
   logic            ill_q;

   logic [6:0] opcode;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] pc_plus4;

   // Index 0 is reset and never written, so it always reads zero.
   assign rs1_val  = regs[rs1[RW-1:0]];
   assign rs2_val  = regs[rs2[RW-1:0]];
   assign imm_i    = XLEN'(signed'(ir[31:20]));
   assign imm_u    = XLEN'(signed'({ir[31:12], 12'b0}));
   assign imm_j    = XLEN'(signed'({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
   assign pc_plus4 = pc + XLEN'(4);

   logic            dec_ok;
   logic            dec_wr;
   logic            dec_ebreak;
   logic            use_rs1;
   logic            use_rs2;
   logic [XLEN-1:0] dec_res;
   logic [XLEN-1:0] dec_npc;
   logic [XLEN-1:0] jalr_sum;

   assign jalr_sum = rs1_val + imm_i;

   always_comb begin
      dec_ok     = 1'b0;
      dec_wr     = 1'b0;
      dec_ebreak = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      dec_res    = '0;
      dec_npc    = pc_plus4;
      case (opcode)
         OPC_OP_IMM: begin
            if (funct3 == 3'b000) begin
               dec_ok  = 1'b1;
               dec_wr  = 1'b1;
               use_rs1 = 1'b1;
               dec_res = rs1_val + imm_i;
            end
         end
         OPC_OP: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
               dec_ok  = 1'b1;
               dec_wr  = 1'b1;
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               dec_res = rs1_val + rs2_val;
            end
         end
         OPC_LUI: begin
            dec_ok  = 1'b1;
            dec_wr  = 1'b1;
            dec_res = imm_u;
         end
         OPC_AUIPC: begin
            dec_ok  = 1'b1;
            dec_wr  = 1'b1;
            dec_res = pc + imm_u;
         end
         OPC_JAL: begin
            dec_ok  = 1'b1;
            dec_wr  = 1'b1;
            dec_res = pc_plus4;
            dec_npc = pc + imm_j;
         end
         OPC_JALR: begin
            if (funct3 == 3'b000) begin
               dec_ok  = 1'b1;
               dec_wr  = 1'b1;
               use_rs1 = 1'b1;
               dec_res = pc_plus4;
               dec_npc = jalr_sum & ~XLEN'(1);
            end
         end
         default: begin
            dec_ebreak = (ir == INST_EBREAK);
         end
      endcase
`ifdef MULTICYCLE_RV32E_EN
      // Upper register indices do not exist in the reduced file; trap instead of aliasing.
      if ((dec_wr && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])) begin
         dec_ok = 1'b0;
         dec_wr = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      retire   = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               state_nx = EXEC;
            end
         end
         EXEC: begin
            state_nx = dec_ok ? WB : HALT;
         end
         WB: begin
            retire   = 1'b1;
            state_nx = FETCH;
         end
         HALT: begin
            state_nx = HALT;
         end
         default: begin
            state_nx = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         ir    <= '0;
         res_q <= '0;
         npc_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= '0;
         ill_q <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  ir <= imem_rdata;
               end
            end
            EXEC: begin
               res_q <= dec_res;
               npc_q <= dec_npc;
               wr_q  <= dec_wr;
               rd_q  <= rd[RW-1:0];
               if (!dec_ok && !dec_ebreak) begin
                  ill_q <= 1'b1;
               end
            end
            WB: begin
               pc <= npc_q;
               if (wr_q && rd_q != '0) begin
                  regs[rd_q] <= res_q;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign imem_addr = pc;
   assign halt      = (state == HALT);
   assign illegal   = ill_q;
   assign halt_ret  = regs[RW'(10)];

endmodule
